// File: rtl/mt_prng_pkg.sv
// Shared types, parameter sets and tempering helper for the Mersenne-Twister stream.
package mt_prng_pkg;

  typedef enum logic {SEED, RUN} mt_state_e;

  // Widest word supported by the tempering helper.
  localparam int unsigned TEMPER_W = 64;

  // MT19937 (32-bit)
  localparam int unsigned MT19937_W = 32;
  localparam int unsigned MT19937_N = 624;
  localparam int unsigned MT19937_M = 397;
  localparam int unsigned MT19937_R = 31;
  localparam logic [31:0] MT19937_A = 32'h9908B0DF;
  localparam int unsigned MT19937_U = 11;
  localparam logic [31:0] MT19937_D = 32'hFFFFFFFF;
  localparam int unsigned MT19937_S = 7;
  localparam logic [31:0] MT19937_B = 32'h9D2C5680;
  localparam int unsigned MT19937_T = 15;
  localparam logic [31:0] MT19937_C = 32'hEFC60000;
  localparam int unsigned MT19937_L = 18;
  localparam logic [31:0] MT19937_F = 32'd1812433253;

  // MT19937-64
  localparam int unsigned MT19937_64_W = 64;
  localparam int unsigned MT19937_64_N = 312;
  localparam int unsigned MT19937_64_M = 156;
  localparam int unsigned MT19937_64_R = 31;
  localparam logic [63:0] MT19937_64_A = 64'hB5026F5AA96619E9;
  localparam int unsigned MT19937_64_U = 29;
  localparam logic [63:0] MT19937_64_D = 64'h5555555555555555;
  localparam int unsigned MT19937_64_S = 17;
  localparam logic [63:0] MT19937_64_B = 64'h71D67FFFEDA60000;
  localparam int unsigned MT19937_64_T = 37;
  localparam logic [63:0] MT19937_64_C = 64'hFFF7EEE000000000;
  localparam int unsigned MT19937_64_L = 43;
  localparam logic [63:0] MT19937_64_F = 64'd6364136223846793005;

  // Tempering transform. Words narrower than TEMPER_W arrive zero-extended and
  // the masks are zero-extended too, so bits above the word width stay clear.
  function automatic logic [TEMPER_W-1:0] temper(
    input logic [TEMPER_W-1:0] x,
    input int unsigned         u,
    input logic [TEMPER_W-1:0] d,
    input int unsigned         s,
    input logic [TEMPER_W-1:0] b,
    input int unsigned         t,
    input logic [TEMPER_W-1:0] c,
    input int unsigned         l
  );
    logic [TEMPER_W-1:0] z;
    z = x;
    z = z ^ ((z >> u) & d);
    z = z ^ ((z << s) & b);
    z = z ^ ((z << t) & c);
    z = z ^ (z >> l);
    return z;
  endfunction

endpackage

// File: rtl/mt_state_buf.sv
// N x W state buffer: one write port, three combinational reads at base, base+1
// and base+M, all modulo N.
module mt_state_buf #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 624,
  parameter int unsigned M  = 397,
  parameter int unsigned AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_base,
  output logic [W-1:0]  rd_i,
  output logic [W-1:0]  rd_i1,
  output logic [W-1:0]  rd_m
);

  logic [W-1:0]  mem [N];
  logic [AW-1:0] addr_i1;
  logic [AW-1:0] addr_m;
  logic [AW:0]   sum_m;

  // Modulo-N neighbour addresses; base is always below N so one correction suffices.
  always_comb begin
    addr_i1 = (rd_base == AW'(N - 1)) ? '0 : rd_base + 1'b1;
    sum_m   = {1'b0, rd_base} + (AW + 1)'(M);
    addr_m  = (sum_m >= (AW + 1)'(N)) ? AW'(sum_m - (AW + 1)'(N)) : sum_m[AW-1:0];
  end

  assign rd_i  = mem[rd_base];
  assign rd_i1 = mem[addr_i1];
  assign rd_m  = mem[addr_m];

  // Single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mt_prng_stream.sv
// Parametrised Mersenne-Twister generator with hardware seeding and a
// valid/ready output stream.
module mt_prng_stream
  import mt_prng_pkg::*;
#(
  parameter int unsigned W            = 32,
  parameter int unsigned N            = 624,
  parameter int unsigned M            = 397,
  parameter int unsigned R            = 31,
  parameter logic [W-1:0] A           = W'(32'h9908B0DF),
  parameter int unsigned U            = 11,
  parameter logic [W-1:0] D           = W'(32'hFFFFFFFF),
  parameter int unsigned S            = 7,
  parameter logic [W-1:0] B           = W'(32'h9D2C5680),
  parameter int unsigned T            = 15,
  parameter logic [W-1:0] C           = W'(32'hEFC60000),
  parameter int unsigned L            = 18,
  parameter logic [W-1:0] F           = W'(32'd1812433253),
  parameter logic [W-1:0] DEFAULT_SEED = W'(32'd5489)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  input  logic [W-1:0] seed,
  output logic         busy,
  output logic         rv_valid,
  input  logic         rv_ready,
  output logic [W-1:0] rv
);

  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LOWER_MASK = {{(W - R){1'b0}}, {R{1'b1}}};
  localparam logic [W-1:0] UPPER_MASK = ~LOWER_MASK;

  if (R >= W) begin : g_bad_r
    $error("mt_prng_stream: R must be less than W");
  end
  if (M >= N) begin : g_bad_m
    $error("mt_prng_stream: M must be less than N");
  end

  mt_state_e     state;
  logic [AW-1:0] i;
  logic [AW-1:0] k;
  logic [AW-1:0] rd_base;
  logic [W-1:0]  rd_i;
  logic [W-1:0]  rd_i1;
  logic [W-1:0]  rd_m;
  logic          load;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  seed_next;
  logic [W-1:0]  y;
  logic [W-1:0]  xn;
  logic [W-1:0]  tz;

  // While seeding, the base read port supplies x[k-1]; while running it supplies x[i].
  assign rd_base = (state == SEED) ? k - 1'b1 : i;

  mt_state_buf #(
    .W  (W),
    .N  (N),
    .M  (M),
    .AW (AW)
  ) u_buf (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_base (rd_base),
    .rd_i    (rd_i),
    .rd_i1   (rd_i1),
    .rd_m    (rd_m)
  );

  // Seeding recurrence, twist and temper for the current index.
  always_comb begin
    seed_next = F * (rd_i ^ (rd_i >> (W - 2))) + W'(k);
    y         = (rd_i & UPPER_MASK) | (rd_i1 & LOWER_MASK);
    xn        = rd_m ^ (y >> 1) ^ ({W{y[0]}} & A);
    tz        = W'(temper(TEMPER_W'(xn), U, TEMPER_W'(D), S, TEMPER_W'(B),
                          T, TEMPER_W'(C), L));
  end

  // Buffer write selection: reset and reseed write x[0], then seeding, then twist.
  always_comb begin
    load  = (state == RUN) && (!rv_valid || rv_ready);
    we    = 1'b0;
    waddr = i;
    wdata = xn;
    if (rst) begin
      we    = 1'b1;
      waddr = '0;
      wdata = DEFAULT_SEED;
    end else if (seed_valid) begin
      we    = 1'b1;
      waddr = '0;
      wdata = seed;
    end else if (state == SEED) begin
      we    = 1'b1;
      waddr = k;
      wdata = seed_next;
    end else if (load) begin
      we    = 1'b1;
      waddr = i;
      wdata = xn;
    end
  end

  // Control FSM and registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv       <= '0;
      rv_valid <= 1'b0;
      busy     <= 1'b1;
      state    <= SEED;
      k        <= AW'(1);
      i        <= '0;
    end else if (seed_valid) begin
      k        <= AW'(1);
      state    <= SEED;
      busy     <= 1'b1;
      rv_valid <= 1'b0;
    end else begin
      case (state)
        SEED: begin
          if (k == AW'(N - 1)) begin
            state <= RUN;
            i     <= '0;
            busy  <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            rv       <= tz;
            rv_valid <= 1'b1;
            i        <= (i == AW'(N - 1)) ? '0 : i + 1'b1;
          end
        end
        default: state <= SEED;
      endcase
    end
  end

endmodule

// File: tb/tb_mt_prng_stream.sv
// Directed bench for mt_prng_stream against a software Mersenne-Twister model.
module tb_mt_prng_stream;
  import mt_prng_pkg::*;

  localparam int unsigned NN = 624;

  logic        clk;
  logic        rst;
  logic        seed_valid;
  logic [31:0] seed;
  logic        busy;
  logic        rv_valid;
  logic        rv_ready;
  logic [31:0] rv;

  logic        busy64;
  logic        rv_valid64;
  logic [63:0] rv64;
  logic        seed_valid64;
  logic [63:0] seed64;
  logic        rv_ready64;

  int vectors;
  int miscompares;

  mt_prng_stream dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .busy       (busy),
    .rv_valid   (rv_valid),
    .rv_ready   (rv_ready),
    .rv         (rv)
  );

  mt_prng_stream #(
    .W (MT19937_64_W), .N (MT19937_64_N), .M (MT19937_64_M), .R (MT19937_64_R),
    .A (MT19937_64_A), .U (MT19937_64_U), .D (MT19937_64_D), .S (MT19937_64_S),
    .B (MT19937_64_B), .T (MT19937_64_T), .C (MT19937_64_C), .L (MT19937_64_L),
    .F (MT19937_64_F), .DEFAULT_SEED (64'd5489)
  ) dut64 (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid64),
    .seed       (seed64),
    .busy       (busy64),
    .rv_valid   (rv_valid64),
    .rv_ready   (rv_ready64),
    .rv         (rv64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- software reference model (MT19937) ----------------
  int unsigned mt_arr [NN];
  int          mti;
  int unsigned head;       // next word the DUT must present
  int unsigned cur_seed;

  function automatic int unsigned model_gen();
    int unsigned yy;
    int unsigned x;
    yy = (mt_arr[mti] & 32'h8000_0000) | (mt_arr[(mti + 1) % NN] & 32'h7FFF_FFFF);
    x  = mt_arr[(mti + 397) % NN] ^ (yy >> 1) ^ (yy[0] ? 32'h9908B0DF : 32'h0);
    mt_arr[mti] = x;
    mti = (mti + 1) % NN;
    x = x ^ (x >> 11);
    x = x ^ ((x << 7) & 32'h9D2C5680);
    x = x ^ ((x << 15) & 32'hEFC60000);
    x = x ^ (x >> 18);
    return x;
  endfunction

  function automatic void model_seed(input int unsigned s);
    mt_arr[0] = s;
    for (int j = 1; j < NN; j++) begin
      mt_arr[j] = 32'd1812433253 * (mt_arr[j-1] ^ (mt_arr[j-1] >> 30)) + 32'(j);
    end
    mti      = 0;
    cur_seed = s;
    head     = model_gen();
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // ---------------- compare process ----------------
  int          cnt;        // edges since the last seeding edge
  bit          armed;
  int          acc_n;      // words accepted since the last seeding edge
  bit          prev_stall;
  logic [31:0] prev_rv;
  bit          chk64_done;

  initial begin
    armed = 0; cnt = 0; acc_n = 0; prev_stall = 0; prev_rv = '0; chk64_done = 0;
  end

  always @(negedge clk) begin
    if (armed && !rst && !seed_valid) begin
      check("busy", busy, (cnt < NN - 1));
      check("rv_valid", rv_valid, (cnt >= NN));
      if (prev_stall) check("stall_hold", rv, prev_rv);
      if (rv_valid) begin
        check("rv", rv, head);
        if (cur_seed == 5489 && acc_n == 0) check("first_word_5489", rv, 64'd3499211612);
        if (cur_seed == 5489 && acc_n == 9999) check("word_10000", rv, 64'd4123659995);
      end
      prev_stall = rv_valid && !rv_ready;
      prev_rv    = rv;
      if (rv_valid && rv_ready) begin
        head = model_gen();
        acc_n++;
      end
    end
    if (rst || seed_valid) begin
      cnt = 0; armed = 1; acc_n = 0; prev_stall = 0;
    end else if (cnt < 1000000) begin
      cnt++;
    end
    if (!rst && !chk64_done && rv_valid64) begin
      check("mt64_first_word", rv64, 64'd14514284786278117030);
      chk64_done = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_rst();
    rst = 1'b1;
    model_seed(32'd5489);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_seed(input logic [31:0] s);
    seed_valid = 1'b1;
    seed       = s;
    model_seed(s);
    @(posedge clk); #1;
    seed_valid = 1'b0;
    seed       = '0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c;
    c = 0;
    while (acc_n < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (acc_n < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_words: got %0d words, required %0d", acc_n, n);
    end
  endtask

  initial begin
    int unsigned w;
    int unsigned lit [5];
    vectors = 0; miscompares = 0;
    rst = 1'b1; seed_valid = 1'b0; seed = '0; rv_ready = 1'b1;
    seed_valid64 = 1'b0; seed64 = '0; rv_ready64 = 1'b1;

    // Pin the model against published reference values.
    lit[0] = 32'd3499211612; lit[1] = 32'd581869302; lit[2] = 32'd3890346734;
    lit[3] = 32'd3586334585; lit[4] = 32'd545404204;
    model_seed(32'd5489);
    w = head;
    for (int j = 0; j < 10000; j++) begin
      if (j < 5) check("model_word", w, lit[j]);
      if (j == 9999) check("model_word_10000", w, 64'd4123659995);
      w = model_gen();
    end
    model_seed(32'd5489);

    // Reset for three edges, then stream 10000 unthrottled words.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_words(10000, 11000);

    // Backpressure: ~40% ready duty.
    for (int j = 0; j < 2000; j++) begin
      rv_ready = ($urandom_range(0, 99) < 40);
      @(posedge clk); #1;
    end
    rv_ready = 1'b1;

    // Mid-stream reseed with 5489 while a word is pending and ready is high.
    pulse_rst();
    wait_words(1000, 2000);
    pulse_seed(32'd5489);
    wait_words(5, 800);

    // Reseed during SEED, then stream past two index wraps.
    pulse_seed(32'h12345678);
    repeat (100) @(posedge clk);
    #1;
    pulse_seed(32'h12345678);
    wait_words(2 * NN + 5, 3000);

    // Stall with a pending word, then release.
    rv_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rv_ready = 1'b1;
    wait_words(2 * NN + 10, 100);

    // Reset during RUN, then reseed again with a pending stalled word.
    pulse_rst();
    wait_words(20, 800);
    rv_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse_seed(32'h12345678);
    rv_ready = 1'b1;
    wait_words(50, 800);

    if (!chk64_done) begin
      vectors++;
      miscompares++;
      $display("FAIL mt64_first_word: got no word, required 14514284786278117030");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
